// File: rtl/fp_pkg.sv
// Shared FP32 helpers: sign-based ReLU and unsigned max on rectified bit patterns.
package fp_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

    // Any word with the sign bit set (negatives, -0, negative NaN) rectifies to +0.
    function automatic logic [FP_W-1:0] relu32(input logic [FP_W-1:0] x);
        return x[SIGN_BIT] ? FP_ZERO : x;
    endfunction

    // Valid only for non-negative patterns, where integer order matches FP order.
    function automatic logic [FP_W-1:0] umax32(input logic [FP_W-1:0] a,
                                               input logic [FP_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer holding the even-row pair maxima; synchronous read.
module pool_line_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 14,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; every entry is rewritten each even row.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read is launched on the even column so the word is ready for the odd column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fp_relu_maxpool.sv
// Streaming FP32 ReLU followed by 2x2/stride-2 max-pool over a raster-order feature map.
module fp_relu_maxpool
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FMAP_W     = 28,
    parameter int unsigned FMAP_H     = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned HALF_W = FMAP_W / 2;
    localparam int unsigned COL_W  = (FMAP_W > 2) ? $clog2(FMAP_W) : 1;
    localparam int unsigned ROW_W  = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;
    localparam int unsigned ADDR_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    if (DATA_WIDTH != 32 || FMAP_W < 2 || (FMAP_W % 2) != 0 ||
        FMAP_H < 2 || (FMAP_H % 2) != 0) begin : g_bad_params
        $error("fp_relu_maxpool: DATA_WIDTH must be 32 and FMAP_W/FMAP_H even and >= 2");
    end

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic                  col_last, row_last, col_odd, row_odd;
    logic [DATA_WIDTH-1:0] relu_v, pair_max, lb_rdata;
    logic [ADDR_W-1:0]     lb_addr;
    logic                  lb_we, lb_re;

    assign col_last = (col_q == COL_W'(FMAP_W - 1));
    assign row_last = (row_q == ROW_W'(FMAP_H - 1));
    assign col_odd  = col_q[0];
    assign row_odd  = row_q[0];
    assign relu_v   = relu32(in_data);
    assign pair_max = umax32(pair_q, relu_v);
    assign lb_addr  = ADDR_W'(col_q >> 1);
    assign lb_we    = in_valid & col_odd & ~row_odd;
    assign lb_re    = in_valid & ~col_odd & row_odd;

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HALF_W),
        .ADDR_W     (ADDR_W)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair_max),
        .re_i    (lb_re),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    // Everything advances only on an accepted pixel; gaps hold all state.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_odd) begin
                pair_d = relu_v;
            end else if (row_odd) begin
                out_valid_d = 1'b1;
                out_data_d  = umax32(pair_max, lb_rdata);
                out_last_d  = row_last & col_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fp_relu_maxpool.sv
// Scoreboard bench: a 4x4 instance for directed windows and a 28x28 instance for random frames.
module tb_fp_relu_maxpool;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv_s, ov_s, ol_s, iv_b, ov_b, ol_b;
    logic [31:0] id_s, od_s, id_b, od_b;

    exp_t        q_s[$];
    exp_t        q_b[$];
    logic [31:0] fr[$];
    logic [31:0] stim[$];

    int errors = 0;
    int checks = 0;
    int lasts_s = 0, lasts_b = 0, exp_lasts_s = 0, exp_lasts_b = 0, outs_b = 0;

    always #5 clk = ~clk;

    fp_relu_maxpool #(.DATA_WIDTH(32), .FMAP_W(4), .FMAP_H(4)) dut_s (
        .clk(clk), .reset(reset), .in_valid(iv_s), .in_data(id_s),
        .out_valid(ov_s), .out_data(od_s), .out_last(ol_s)
    );

    fp_relu_maxpool #(.DATA_WIDTH(32), .FMAP_W(28), .FMAP_H(28)) dut_b (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_data(id_b),
        .out_valid(ov_b), .out_data(od_b), .out_last(ol_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rectify(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    // Reference: every 2x2 window completed within the first n pixels of fr yields its max.
    task automatic model(input bit big, input int w, input int h, input int n);
        for (int idx = 0; idx < n; idx++) begin
            int r, c;
            logic [31:0] m, v;
            exp_t e;
            r = idx / w;
            c = idx % w;
            if ((r % 2) == 1 && (c % 2) == 1) begin
                m = 32'h0;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        v = rectify(fr[(r - dr) * w + (c - dc)]);
                        if (v > m) m = v;
                    end
                end
                e.d    = m;
                e.last = (r == h - 1) && (c == w - 1);
                if (big) begin
                    q_b.push_back(e);
                    if (e.last) exp_lasts_b++;
                end else begin
                    q_s.push_back(e);
                    if (e.last) exp_lasts_s++;
                end
            end
        end
    endtask

    task automatic push_s(input logic [31:0] d, input logic last);
        exp_t e;
        e.d = d;
        e.last = last;
        q_s.push_back(e);
        if (last) exp_lasts_s++;
    endtask

    task automatic stream(input bit big, input int maxgap);
        foreach (stim[i]) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            if (big) begin
                iv_b = 1'b1;
                id_b = stim[i];
            end else begin
                iv_s = 1'b1;
                id_s = stim[i];
            end
            @(posedge clk);
            #1;
            iv_s = 1'b0;
            iv_b = 1'b0;
            id_s = $urandom;
            id_b = $urandom;
        end
        stim.delete();
    endtask

    task automatic rand_frame(input int n, input bit neg_only);
        fr.delete();
        for (int i = 0; i < n; i++) begin
            fr.push_back(neg_only ? ($urandom | 32'h8000_0000) : $urandom);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (q_s.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_small", 32'(q_s.size()), 32'h0);
        chk("drain_big", 32'(q_b.size()), 32'h0);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid_s"}, 32'(ov_s), 32'h0);
        chk({tag, "_data_s"}, od_s, 32'h0);
        chk({tag, "_last_s"}, 32'(ol_s), 32'h0);
        chk({tag, "_valid_b"}, 32'(ov_b), 32'h0);
        chk({tag, "_data_b"}, od_b, 32'h0);
        chk({tag, "_last_b"}, 32'(ol_b), 32'h0);
    endtask

    // Monitors pop the oldest expectation whenever a DUT presents a pooled word.
    always @(negedge clk) begin
        exp_t e;
        if (ov_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL small_spurious: got out_valid=1 data %h, expected no output", od_s);
            end else begin
                e = q_s.pop_front();
                chk("small_data", od_s, e.d);
                chk("small_last", 32'(ol_s), 32'(e.last));
            end
            if (ol_s) lasts_s++;
        end else if (ol_s) begin
            chk("small_last_without_valid", 32'(ol_s), 32'h0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov_b) begin
            outs_b++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL big_spurious: got out_valid=1 data %h, expected no output", od_b);
            end else begin
                e = q_b.pop_front();
                chk("big_data", od_b, e.d);
                chk("big_last", 32'(ol_b), 32'(e.last));
            end
            if (ol_b) lasts_b++;
        end else if (ol_b) begin
            chk("big_last_without_valid", 32'(ol_b), 32'h0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_lasts, base_outs;
        reset = 1'b1;
        iv_s = 1'b0; id_s = '0;
        iv_b = 1'b0; id_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset");

        // Directed 4x4 frame with known windows.
        stim = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000,
                 32'hC0400000, 32'h3F000000, 32'h40800000, 32'h3F000000,
                 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000};
        push_s(32'h40000000, 1'b0);
        push_s(32'h40800000, 1'b0);
        push_s(32'h00000000, 1'b0);
        push_s(32'h00000000, 1'b1);
        stream(1'b0, 0);
        drain();

        // All-negative frame including -0: every output must be +0.
        rand_frame(16, 1'b1);
        fr[0] = 32'h8000_0000;
        fr[7] = 32'h8000_0000;
        fr[10] = 32'h8000_0000;
        fr[15] = 32'h8000_0000;
        stim = fr;
        push_s(32'h0, 1'b0);
        push_s(32'h0, 1'b0);
        push_s(32'h0, 1'b0);
        push_s(32'h0, 1'b1);
        stream(1'b0, 2);
        drain();

        // Positive NaN wins its window; negative NaN rectifies to zero.
        rand_frame(16, 1'b1);
        fr[5] = 32'h7FC00000;
        fr[15] = 32'hFFC00000;
        fr[14] = 32'hFFC00000;
        stim = fr;
        push_s(32'h7FC00000, 1'b0);
        push_s(32'h0, 1'b0);
        push_s(32'h0, 1'b0);
        push_s(32'h0, 1'b1);
        stream(1'b0, 3);
        drain();

        // Two random frames back-to-back without gaps.
        base_lasts = lasts_s;
        for (int f = 0; f < 2; f++) begin
            rand_frame(16, 1'b0);
            model(1'b0, 4, 4, 16);
            foreach (fr[i]) stim.push_back(fr[i]);
        end
        stream(1'b0, 0);
        drain();
        chk("b2b_last_count", 32'(lasts_s - base_lasts), 32'd2);

        // Full 28x28 random frame with random gaps.
        base_outs = outs_b;
        rand_frame(784, 1'b0);
        model(1'b1, 28, 28, 784);
        stim = fr;
        stream(1'b1, 5);
        drain();
        chk("big_output_count", 32'(outs_b - base_outs), 32'd196);

        // Abort after 37 inputs, then a clean frame from pixel (0,0).
        rand_frame(784, 1'b0);
        model(1'b1, 28, 28, 37);
        for (int i = 0; i < 37; i++) stim.push_back(fr[i]);
        stream(1'b1, 2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("midreset");
        chk("abort_pending", 32'(q_b.size()), 32'h0);
        base_outs = outs_b;
        rand_frame(784, 1'b0);
        model(1'b1, 28, 28, 784);
        stim = fr;
        stream(1'b1, 1);
        drain();
        chk("post_reset_count", 32'(outs_b - base_outs), 32'd196);

        chk("small_last_total", 32'(lasts_s), 32'(exp_lasts_s));
        chk("big_last_total", 32'(lasts_b), 32'(exp_lasts_b));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
